// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage definitions: ALU op codes, multiplier FSM states,
// and the architectural word width.
package rv_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] ALU_ADD    = 5'b00000;
   localparam logic [4:0] ALU_SUB    = 5'b00001;
   localparam logic [4:0] ALU_SLL    = 5'b00010;
   localparam logic [4:0] ALU_SLT    = 5'b00011;
   localparam logic [4:0] ALU_SLTU   = 5'b00100;
   localparam logic [4:0] ALU_XOR    = 5'b00101;
   localparam logic [4:0] ALU_SRL    = 5'b00110;
   localparam logic [4:0] ALU_SRA    = 5'b00111;
   localparam logic [4:0] ALU_OR     = 5'b01000;
   localparam logic [4:0] ALU_AND    = 5'b01001;
   localparam logic [4:0] ALU_LUI    = 5'b01010;
   localparam logic [4:0] ALU_MUL    = 5'b01011;
   localparam logic [4:0] ALU_MULH   = 5'b01100;
   localparam logic [4:0] ALU_MULHSU = 5'b01101;
   localparam logic [4:0] ALU_MULHU  = 5'b01110;
   localparam logic [4:0] ALU_DIV    = 5'b01111;
   localparam logic [4:0] ALU_DIVU   = 5'b10000;
   localparam logic [4:0] ALU_REM    = 5'b10001;
   localparam logic [4:0] ALU_REMU   = 5'b10010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mul_state_e;

   function automatic logic is_mul_op(input logic [4:0] op);
      return (op == ALU_MUL) || (op == ALU_MULH) ||
             (op == ALU_MULHSU) || (op == ALU_MULHU);
   endfunction

endpackage

// File: rtl/mul_operand_prep.sv
// Converts raw operands to magnitudes according to the signedness of the
// multiply op, and reports whether the final product must be negated.
module mul_operand_prep
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [4:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_mag_a,
   output logic [XLEN-1:0] o_mag_b,
   output logic            o_neg_sign
);

   logic w_sign_a;
   logic w_sign_b;

   // MUL's low word is sign-agnostic, so it shares the unsigned path.
   assign w_sign_a = ((i_op == ALU_MULH) || (i_op == ALU_MULHSU)) && i_a[XLEN-1];
   assign w_sign_b = (i_op == ALU_MULH) && i_b[XLEN-1];

   assign o_mag_a    = w_sign_a ? (~i_a + 1'b1) : i_a;
   assign o_mag_b    = w_sign_b ? (~i_b + 1'b1) : i_b;
   assign o_neg_sign = w_sign_a ^ w_sign_b;

endmodule

// File: rtl/mul_iterative.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU; stalls EX for a
// fixed 34 cycles and presents the selected product word with a one-cycle flagM.
//
// state | meaning
// IDLE  | waiting for an accepted multiply; operands latched on accept
// CALC  | one shift-add step per cycle, XLEN steps total
// FIX   | apply sign correction and select the result word
// DONE  | flagM high for one cycle; pipeline released
module mul_iterative
   import rv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mul_use,
   input  logic [4:0]      alu_opE,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic            flush,
   output logic            busy,
   output logic            flagM,
   output logic [XLEN-1:0] result_m
);

   mul_state_e          r_state;
   mul_state_e          w_next_state;
   logic [CNT_W-1:0]    r_count;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_mcand;
   logic                r_neg;
   logic [4:0]          r_op;
   logic                r_flag;
   logic [XLEN-1:0]     r_result;

   logic                w_accept;
   logic [XLEN-1:0]     w_mag_a;
   logic [XLEN-1:0]     w_mag_b;
   logic                w_neg;
   logic [XLEN:0]       w_sum;
   logic [2*XLEN-1:0]   w_acc_step;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_fix_word;

   mul_operand_prep #(.XLEN(XLEN)) u_prep (
      .i_op       (alu_opE),
      .i_a        (SrcAE),
      .i_b        (SrcBE),
      .o_mag_a    (w_mag_a),
      .o_mag_b    (w_mag_b),
      .o_neg_sign (w_neg)
   );

   assign w_accept = (r_state == IDLE) && mul_use && is_mul_op(alu_opE) && !flush;

   // Multiplier sits in the low half; the carry of each add shifts into the top bit.
   assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
   assign w_acc_step = {w_sum, r_acc[XLEN-1:1]};
   assign w_prod     = r_neg ? (~r_acc + 1'b1) : r_acc;
   assign w_fix_word = (r_op == ALU_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE: if (w_accept) w_next_state = CALC;
         CALC: begin
            if (flush)                                w_next_state = IDLE;
            else if (r_count == CNT_W'(XLEN - 1))     w_next_state = FIX;
         end
         FIX:  w_next_state = flush ? IDLE : DONE;
         DONE: w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_neg    <= 1'b0;
         r_op     <= '0;
         r_flag   <= 1'b0;
         r_result <= '0;
      end else begin
         r_state <= w_next_state;
         r_flag  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mcand <= w_mag_a;
                  r_acc   <= {{XLEN{1'b0}}, w_mag_b};
                  r_neg   <= w_neg;
                  r_op    <= alu_opE;
                  r_count <= '0;
               end
            end
            CALC: begin
               if (!flush) begin
                  r_acc   <= w_acc_step;
                  r_count <= r_count + CNT_W'(1);
               end
            end
            FIX: begin
               if (!flush) begin
                  r_result <= w_fix_word;
                  r_flag   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = ((r_state == IDLE) && w_accept) || (r_state == CALC) || (r_state == FIX);
   assign flagM    = r_flag;
   assign result_m = r_result;

endmodule

// File: doc/mul_iterative.md
Name: mul_iterative

Overview:
- Iterative shift-add multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU).
- Sits in EX, directly upstream of the ALU, alongside it. Accepts operands from the ID/EX register and stalls the pipeline while it iterates.
- Presents the product on result_m, qualified by a one-cycle flagM, which the ALU forwards as ALUResult.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 5, iteration counter width (clog2 XLEN).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mul_use  in  1  EX-stage instruction is a multiply; start request
- alu_opE  in  5  EX-stage ALU op code
- SrcAE  in  32  operand A (rs1, post-forwarding)
- SrcBE  in  32  operand B (rs2, post-forwarding)
- flush  in  1  synchronous abort (branch/trap flush of EX)
- busy  out  1  stall request to hazard unit (freeze PC, IF/ID, ID/EX)
- flagM  out  1  result valid, exactly one cycle per accepted multiply
- result_m  out  32  selected product word

Behaviour:
- Single clock domain: clk. Reset rst_n is asynchronous assert, active-low, and applies to all flops.
- Reset values: state=IDLE, count=0, flagM=0, result_m=0, internal accumulators 0.
- Op codes:
  - MUL=5'b01011 returns product[31:0].
  - MULH=5'b01100: signed x signed, returns [63:32].
  - MULHSU=5'b01101: signed A x unsigned B, returns [63:32].
  - MULHU=5'b01110: unsigned x unsigned, returns [63:32].
  - MUL treats both operands as unsigned; its low word is identical either way.
- Accept condition: state==IDLE && mul_use && alu_opE in {MUL..MULHU} && !flush. Any other op with mul_use=1 is ignored: no busy, no flagM.
- FSM states and transitions:
  - IDLE: on accept, latch |A| and |B|, neg_sign = signA^signB (per-op signedness), and op; count=0; go to CALC.
  - CALC: each cycle, if multiplier LSB is set, add multiplicand into the upper half of the 64-bit accumulator, then shift right 1. count++. When count==31, go to FIX.
  - FIX: apply 64-bit two's-complement negate if neg_sign; select word per op into result_m; go to DONE.
  - DONE: flagM=1; unconditionally return to IDLE. mul_use is ignored in DONE.
- Latency is fixed and independent of operand values, including zero operands:
  - accept edge E0;
  - iterations on edges E1..E32;
  - FIX edge E33;
  - flagM high during the cycle after E33 only.
- busy = (state==IDLE && accept) || state==CALC || state==FIX. busy is 0 in DONE, so the pipeline advances while the ALU consumes result_m.
- result_m holds its value until the next FIX; it is not cleared on flagM falling.
- Magnitude rule: -2^31 maps to 2^31 (fits in 32-bit unsigned). Products use a 64-bit accumulator, and no overflow is possible.
- flush in CALC or FIX: return to IDLE next edge. No flagM; result_m unchanged. flush in DONE: flagM still deasserts next cycle (no effect).
- Reset mid-operation: immediate return to reset values. No flagM on release.
- Back-to-back multiplies: the second is accepted in the IDLE cycle following DONE (minimum one bubble between flagM pulses).

Decomposition:
- Shared package rv_pkg:
  - 5-bit ALU op code constants (ADD..REMU), shared with the ALU and decoder;
  - mul_state_e enum {IDLE, CALC, FIX, DONE};
  - XLEN constant.
- One natural combinational sub-module, mul_operand_prep: takes op and the raw operands; produces magnitudes and neg_sign.
- The FSM and datapath stay in mul_iterative.

Test Plan:
- MUL, A=7, B=6, mul_use=1 -> busy high 34 cycles (E0 through FIX), flagM one cycle after E33, result_m=0x0000002A.
- MUL, A=0xFFFFFFFD (-3), B=5 -> result_m=0xFFFFFFF1. MULH on the same operands -> 0xFFFFFFFF.
- MULH, A=B=0x80000000 -> result_m=0x40000000. MULHU, A=B=0xFFFFFFFF -> result_m=0xFFFFFFFE.
- MULHSU, A=0xFFFFFFFF (-1), B=0xFFFFFFFF -> product 0xFFFFFFFF_00000001, result_m=0xFFFFFFFF.
- Abort cases (prior result 0x2A): rst_n low at cycle 10 of CALC -> busy=0 and result_m=0 immediately, no flagM ever. flush at cycle 10 -> IDLE next edge, no flagM, result_m stays 0x2A.
- Filtering and sequencing:
  - mul_use=1 with alu_opE=ADD -> busy stays 0, no flagM.
  - Two consecutive MULs (3*4, then 5*5) -> two flagM pulses 35 cycles apart, result_m=12, then 25.
